// File: rtl/intr_arbiter_if.sv
// Interrupt arbiter bus: peripheral request lines, mask programming port
// and the CPU-side Intr/Inta/Eoi handshake, bundled into one interface.
// The master modport is the driving side (peripherals and CPU); the slave
// modport is the arbiter itself.
interface intr_arbiter_if #(
   parameter int N_SRC = 8,
   parameter int VEC_W = 3
);
   logic [N_SRC-1:0] Irq;
   logic             Mask_we;
   logic [N_SRC-1:0] Mask_wdata;
   logic             Inta;
   logic             Eoi;
   logic             Intr;
   logic [VEC_W-1:0] Vector;
   logic             Busy;
   logic [N_SRC-1:0] Pending;

   modport master (
      output Irq, Mask_we, Mask_wdata, Inta, Eoi,
      input  Intr, Vector, Busy, Pending
   );

   modport slave (
      input  Irq, Mask_we, Mask_wdata, Inta, Eoi,
      output Intr, Vector, Busy, Pending
   );
endinterface

// File: rtl/intr_arbiter.sv
// Priority interrupt controller. Rising edges on Irq are latched into
// pending bits and filtered by a software mask. One winner is then offered
// to the CPU through an Intr/Inta request, and the controller holds its
// index on Vector until the handler returns Eoi. There is no nesting.
// Optional feature: define INTR_ARB_ROUND_ROBIN_EN for rotating priority.
// Without it, the lowest eligible index wins and no pointer register is built.
module intr_arbiter #(
   parameter int N_SRC = 8,
   parameter int VEC_W = 3
) (
   input logic           Clk,
   input logic           Clrn,
   intr_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      SERV = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [N_SRC-1:0] irq_q;
   logic             armed;
   logic [N_SRC-1:0] mask;
   logic [N_SRC-1:0] pending;
   logic [N_SRC-1:0] pending_next;
   logic [N_SRC-1:0] rise;
   logic [N_SRC-1:0] clr_mask;
   logic [N_SRC-1:0] eligible;
   logic             intr;
   logic             intr_next;
   logic             busy;
   logic             busy_next;
   logic [VEC_W-1:0] vector;
   logic [VEC_W-1:0] vector_next;
   logic [VEC_W-1:0] winner;
   logic             accept;

   assign bus.Intr    = intr;
   assign bus.Vector  = vector;
   assign bus.Busy    = busy;
   assign bus.Pending = pending;

   assign eligible = pending & ~mask;

   // The delay register resets to zero while the lines may already be high.
   // The armed flag therefore ignores the first post-reset cycle, so a line
   // that is high across reset release is treated as level-held, not as an edge.
   assign rise = armed ? (bus.Irq & ~irq_q) : '0;

   // Set wins over clear, so an edge that lands on the acknowledge cycle is kept.
   assign clr_mask     = accept ? (N_SRC'(1) << vector) : '0;
   assign pending_next = (pending & ~clr_mask) | rise;

   // Input history for edge detection plus the one-shot arm flag.
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         irq_q <= '0;
         armed <= 1'b0;
      end else begin
         irq_q <= bus.Irq;
         armed <= 1'b1;
      end
   end

   // Mask register; a write takes part in arbitration from the next cycle.
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         mask <= '0;
      end else if (bus.Mask_we) begin
         mask <= bus.Mask_wdata;
      end
   end

   // Latched pending bits.
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         pending <= '0;
      end else begin
         pending <= pending_next;
      end
   end

`ifdef INTR_ARB_ROUND_ROBIN_EN
   logic [VEC_W-1:0] ptr;
   int               dist;
   int               best;

   // Rotating pointer follows the most recently acknowledged source.
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         ptr <= VEC_W'(N_SRC - 1);
      end else if (accept) begin
         ptr <= vector;
      end
   end

   // Pick the eligible source closest after the pointer, wrapping modulo N_SRC.
   always_comb begin
      winner = '0;
      dist   = 0;
      best   = N_SRC;
      for (int j = 0; j < N_SRC; j++) begin
         dist = (j + N_SRC - 1 - int'(ptr)) % N_SRC;
         if (eligible[j] && (dist < best)) begin
            best   = dist;
            winner = VEC_W'(j);
         end
      end
   end
`else
   // Fixed priority: descending scan so the lowest eligible index is kept last.
   always_comb begin
      winner = '0;
      for (int j = N_SRC - 1; j >= 0; j--) begin
         if (eligible[j]) begin
            winner = VEC_W'(j);
         end
      end
   end
`endif

   // Handshake FSM state and registered outputs.
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         state  <= IDLE;
         intr   <= 1'b0;
         busy   <= 1'b0;
         vector <= '0;
      end else begin
         state  <= state_next;
         intr   <= intr_next;
         busy   <= busy_next;
         vector <= vector_next;
      end
   end

   // Next-state and output decode; the request is never withdrawn once raised.
   always_comb begin
      state_next  = state;
      intr_next   = intr;
      busy_next   = busy;
      vector_next = vector;
      accept      = 1'b0;
      case (state)
         IDLE: begin
            if (|eligible) begin
               vector_next = winner;
               intr_next   = 1'b1;
               state_next  = REQ;
            end
         end
         REQ: begin
            if (bus.Inta) begin
               intr_next  = 1'b0;
               busy_next  = 1'b1;
               accept     = 1'b1;
               state_next = SERV;
            end
         end
         SERV: begin
            if (bus.Eoi) begin
               busy_next  = 1'b0;
               state_next = IDLE;
            end
         end
         default: begin
            intr_next  = 1'b0;
            busy_next  = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_intr_arbiter.sv
// Self-checking bench for intr_arbiter. Expected grant vectors are queued
// when requests are driven and popped when the controller raises Intr.
module tb_intr_arbiter;

   localparam int N_SRC = 8;
   localparam int VEC_W = 3;

   logic clk;
   logic clrn;

   int total_checks;
   int bad_checks;

   logic [VEC_W-1:0] exp_q[$];

   intr_arbiter_if #(.N_SRC(N_SRC), .VEC_W(VEC_W)) bus_if ();

   intr_arbiter #(.N_SRC(N_SRC), .VEC_W(VEC_W)) dut (
      .Clk  (clk),
      .Clrn (clrn),
      .bus  (bus_if)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop if the run ever wedges.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for Intr, check the granted vector against the scoreboard, then
   // acknowledge (optionally driving Irq in the same cycle) and end service.
   task automatic serve_one(input logic [N_SRC-1:0] exp_pend,
                            input logic [N_SRC-1:0] irq_with_inta);
      int               n;
      logic [VEC_W-1:0] exp_vec;
      n = 0;
      while (bus_if.Intr !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      total_checks++;
      if (bus_if.Intr !== 1'b1) begin
         bad_checks++;
         $display("[TB] FAIL grant_timeout: got Intr=%b want 1", bus_if.Intr);
         return;
      end
      total_checks++;
      if (exp_q.size() == 0) begin
         bad_checks++;
         $display("[TB] FAIL unexpected_grant: got Vector=%0d want none", bus_if.Vector);
         return;
      end
      exp_vec = exp_q.pop_front();
      if (bus_if.Vector !== exp_vec) begin
         bad_checks++;
         $display("[TB] FAIL grant_vector: got %0d want %0d", bus_if.Vector, exp_vec);
      end
      bus_if.Inta = 1'b1;
      bus_if.Irq  = irq_with_inta;
      tick();
      bus_if.Inta = 1'b0;
      bus_if.Irq  = '0;
      total_checks++;
      if (bus_if.Intr !== 1'b0 || bus_if.Busy !== 1'b1) begin
         bad_checks++;
         $display("[TB] FAIL inta_outputs: got Intr=%b Busy=%b want Intr=0 Busy=1",
                  bus_if.Intr, bus_if.Busy);
      end
      total_checks++;
      if (bus_if.Pending !== exp_pend) begin
         bad_checks++;
         $display("[TB] FAIL inta_pending: got %h want %h", bus_if.Pending, exp_pend);
      end
      tick();
      total_checks++;
      if (bus_if.Vector !== exp_vec || bus_if.Busy !== 1'b1) begin
         bad_checks++;
         $display("[TB] FAIL serv_hold: got Vector=%0d Busy=%b want Vector=%0d Busy=1",
                  bus_if.Vector, bus_if.Busy, exp_vec);
      end
      bus_if.Eoi = 1'b1;
      tick();
      bus_if.Eoi = 1'b0;
      total_checks++;
      if (bus_if.Busy !== 1'b0 || bus_if.Intr !== 1'b0) begin
         bad_checks++;
         $display("[TB] FAIL eoi_outputs: got Busy=%b Intr=%b want 0 0",
                  bus_if.Busy, bus_if.Intr);
      end
   endtask

   task automatic test_reset();
      logic saw_intr;
      $display("[TB] test_reset");
      clrn       = 1'b0;
      bus_if.Irq = 8'hFF;
      #3;
      total_checks++;
      if (bus_if.Intr !== 1'b0 || bus_if.Busy !== 1'b0) begin
         bad_checks++;
         $display("[TB] FAIL reset_ctrl: got Intr=%b Busy=%b want 0 0", bus_if.Intr, bus_if.Busy);
      end
      total_checks++;
      if (bus_if.Vector !== '0 || bus_if.Pending !== '0) begin
         bad_checks++;
         $display("[TB] FAIL reset_data: got Vector=%0d Pending=%h want 0 00",
                  bus_if.Vector, bus_if.Pending);
      end
      tick();
      tick();
      clrn     = 1'b1;
      saw_intr = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus_if.Intr !== 1'b0) saw_intr = 1'b1;
      end
      total_checks++;
      if (saw_intr !== 1'b0) begin
         bad_checks++;
         $display("[TB] FAIL held_level_no_intr: got Intr seen=%b want 0", saw_intr);
      end
      total_checks++;
      if (bus_if.Pending !== '0) begin
         bad_checks++;
         $display("[TB] FAIL held_level_pending: got %h want 00", bus_if.Pending);
      end
      bus_if.Irq = '0;
      tick();
      tick();
   endtask

   task automatic test_single_source();
      $display("[TB] test_single_source");
      exp_q.push_back(3'd5);
      bus_if.Irq = 8'h20;
      tick();
      bus_if.Irq = '0;
      total_checks++;
      if (bus_if.Pending !== 8'h20 || bus_if.Intr !== 1'b0) begin
         bad_checks++;
         $display("[TB] FAIL single_e0: got Pending=%h Intr=%b want 20 0",
                  bus_if.Pending, bus_if.Intr);
      end
      tick();
      total_checks++;
      if (bus_if.Intr !== 1'b1) begin
         bad_checks++;
         $display("[TB] FAIL single_latency: got Intr=%b want 1", bus_if.Intr);
      end
      serve_one(8'h00, 8'h00);
   endtask

   task automatic test_stray_eoi();
      $display("[TB] test_stray_eoi");
      bus_if.Eoi = 1'b1;
      tick();
      bus_if.Eoi = 1'b0;
      tick();
      total_checks++;
      if (bus_if.Busy !== 1'b0 || bus_if.Intr !== 1'b0) begin
         bad_checks++;
         $display("[TB] FAIL stray_eoi: got Busy=%b Intr=%b want 0 0", bus_if.Busy, bus_if.Intr);
      end
   endtask

   task automatic test_priority();
      $display("[TB] test_priority");
      exp_q.push_back(3'd3);
      bus_if.Irq = 8'h08;
      tick();
      bus_if.Irq = '0;
      serve_one(8'h00, 8'h00);
`ifdef INTR_ARB_ROUND_ROBIN_EN
      exp_q.push_back(3'd6);
      exp_q.push_back(3'd2);
`else
      exp_q.push_back(3'd2);
      exp_q.push_back(3'd6);
`endif
      bus_if.Irq = 8'h44;
      tick();
      bus_if.Irq = '0;
`ifdef INTR_ARB_ROUND_ROBIN_EN
      serve_one(8'h04, 8'h00);
`else
      serve_one(8'h40, 8'h00);
`endif
      serve_one(8'h00, 8'h00);
   endtask

   task automatic test_mask();
      logic saw_intr;
      $display("[TB] test_mask");
      bus_if.Mask_we    = 1'b1;
      bus_if.Mask_wdata = 8'h10;
      tick();
      bus_if.Mask_we = 1'b0;
      bus_if.Irq     = 8'h10;
      tick();
      bus_if.Irq = '0;
      saw_intr   = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus_if.Intr !== 1'b0) saw_intr = 1'b1;
      end
      total_checks++;
      if (bus_if.Pending !== 8'h10 || saw_intr !== 1'b0) begin
         bad_checks++;
         $display("[TB] FAIL masked_hold: got Pending=%h Intr seen=%b want 10 0",
                  bus_if.Pending, saw_intr);
      end
      exp_q.push_back(3'd4);
      bus_if.Mask_we    = 1'b1;
      bus_if.Mask_wdata = 8'h00;
      tick();
      bus_if.Mask_we = 1'b0;
      total_checks++;
      if (bus_if.Intr !== 1'b0) begin
         bad_checks++;
         $display("[TB] FAIL unmask_edge1: got Intr=%b want 0", bus_if.Intr);
      end
      tick();
      total_checks++;
      if (bus_if.Intr !== 1'b1) begin
         bad_checks++;
         $display("[TB] FAIL unmask_edge2: got Intr=%b want 1", bus_if.Intr);
      end
      serve_one(8'h00, 8'h00);
   endtask

   task automatic test_retrigger_race();
      $display("[TB] test_retrigger_race");
      exp_q.push_back(3'd1);
      exp_q.push_back(3'd1);
      bus_if.Irq = 8'h02;
      tick();
      bus_if.Irq = '0;
      serve_one(8'h02, 8'h02);
      serve_one(8'h00, 8'h00);
   endtask

   task automatic test_reset_mid_req();
      int n;
      $display("[TB] test_reset_mid_req");
      bus_if.Mask_we    = 1'b1;
      bus_if.Mask_wdata = 8'h01;
      tick();
      bus_if.Mask_we = 1'b0;
      bus_if.Irq     = 8'h08;
      tick();
      bus_if.Irq = '0;
      n = 0;
      while (bus_if.Intr !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      bus_if.Irq = 8'h40;
      tick();
      bus_if.Irq = '0;
      total_checks++;
      if (bus_if.Intr !== 1'b1 || bus_if.Pending !== 8'h48) begin
         bad_checks++;
         $display("[TB] FAIL pre_reset_req: got Intr=%b Pending=%h want 1 48",
                  bus_if.Intr, bus_if.Pending);
      end
      #2;
      clrn = 1'b0;
      #1;
      total_checks++;
      if (bus_if.Intr !== 1'b0 || bus_if.Pending !== '0 || bus_if.Busy !== 1'b0) begin
         bad_checks++;
         $display("[TB] FAIL async_reset: got Intr=%b Pending=%h Busy=%b want 0 00 0",
                  bus_if.Intr, bus_if.Pending, bus_if.Busy);
      end
      tick();
      clrn = 1'b1;
      tick();
      bus_if.Inta = 1'b1;
      tick();
      bus_if.Inta = 1'b0;
      tick();
      total_checks++;
      if (bus_if.Busy !== 1'b0 || bus_if.Intr !== 1'b0) begin
         bad_checks++;
         $display("[TB] FAIL stray_inta: got Busy=%b Intr=%b want 0 0", bus_if.Busy, bus_if.Intr);
      end
      exp_q.push_back(3'd0);
      bus_if.Irq = 8'h01;
      tick();
      bus_if.Irq = '0;
      serve_one(8'h00, 8'h00);
   endtask

   // Test sequence.
   initial begin
      total_checks      = 0;
      bad_checks        = 0;
      clrn              = 1'b0;
      bus_if.Irq        = '0;
      bus_if.Mask_we    = 1'b0;
      bus_if.Mask_wdata = '0;
      bus_if.Inta       = 1'b0;
      bus_if.Eoi        = 1'b0;

      test_reset();
      test_single_source();
      test_stray_eoi();
      test_priority();
      test_mask();
      test_retrigger_race();
      test_reset_mid_req();

      total_checks++;
      if (exp_q.size() != 0) begin
         bad_checks++;
         $display("[TB] FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule
